// File: rtl/hz_display_pkg.sv
// hz_display_pkg: shared widths, FSM states and BCD sizing helper for the hz display path
package hz_display_pkg;

   typedef enum logic {ST_IDLE, ST_CONV} state_t;

   function automatic int bcd_digits_for(input int width);
      longint lim;
      longint p;
      int     d;
      lim = (longint'(1) << width) - 1;
      p   = 1;
      d   = 0;
      for (int i = 0; i < 20; i++)
         if (p <= lim) begin
            p = p * 10;
            d++;
         end
      return d;
   endfunction

   localparam int METER_WIDTH = 17;
   localparam int DISP_DIGITS = bcd_digits_for(METER_WIDTH);

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add 3 to a BCD nibble that is 5 or more, ahead of the double-dabble shift
module bcd_digit_adj (
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);

   assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/hz_bcd_converter.sv
// hz_bcd_converter: sequential shift-and-add-3 binary to packed BCD with leading-zero mask
module hz_bcd_converter
   import hz_display_pkg::*;
#(
   parameter int WIDTH  = METER_WIDTH,
   parameter int DIGITS = DISP_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst_a_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     nz
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sh;
   logic [BW-1:0]    r_scr;
   logic [BW-1:0]    r_bcd;
   logic [DIGITS-1:0] r_nz;
   logic             r_done;
   logic [BW-1:0]    w_adj;
   logic [BW-1:0]    w_shift;
   logic [DIGITS-1:0] w_nz;
   logic             w_accept;
   logic             w_last;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dig
         bcd_digit_adj u_adj (
            .i_d (r_scr[4*g +: 4]),
            .o_d (w_adj[4*g +: 4])
         );
         // a digit is shown if it or any more significant digit is nonzero; units always shown
         assign w_nz[g] = (g == 0) ? 1'b1 : |w_shift[BW-1:4*g];
      end
   endgenerate

   assign w_shift = {w_adj[BW-2:0], r_sh[WIDTH-1]};

   // next state: accept start only when idle, finish on the WIDTH-th shift
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      if (r_state == ST_IDLE && start) begin
         w_accept    = 1'b1;
         w_state_nxt = ST_CONV;
      end else if (r_state == ST_CONV && r_cnt == CW'(WIDTH - 1)) begin
         w_last      = 1'b1;
         w_state_nxt = ST_IDLE;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // datapath: capture, shift, and publish the result only on the final shift
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_cnt  <= '0;
         r_sh   <= '0;
         r_scr  <= '0;
         r_bcd  <= '0;
         r_nz   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_sh  <= bin;
            r_scr <= '0;
            r_cnt <= '0;
         end else if (r_state == ST_CONV) begin
            r_sh  <= r_sh << 1;
            r_scr <= w_shift;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_last) begin
            r_bcd <= w_shift;
            r_nz  <= w_nz;
         end
      end
   end

   assign busy = (r_state == ST_CONV);
   assign done = r_done;
   assign bcd  = r_bcd;
   assign nz   = r_nz;

endmodule

// File: tb/tb_hz_bcd_converter.sv
// tb_hz_bcd_converter: directed table, handshake corner cases and random sweep for hz_bcd_converter
module tb_hz_bcd_converter;

   localparam int W = 17;
   localparam int D = 6;

   typedef struct {
      logic [W-1:0]   bin;
      logic [4*D-1:0] bcd;
      logic [D-1:0]   nz;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_a_n = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   bin = '0;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;
   logic [D-1:0]   nz;

   int checks = 0;
   int errors = 0;

   hz_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .start   (start),
      .bin     (bin),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd),
      .nz      (nz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4*D-1:0] ref_bcd(input int v);
      logic [4*D-1:0] r;
      int             x;
      r = '0;
      x = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [D-1:0] ref_nz(input logic [4*D-1:0] b);
      logic [D-1:0] m;
      logic         seen;
      m    = '0;
      seen = 1'b0;
      for (int i = D - 1; i >= 0; i--) begin
         if (b[4*i +: 4] != 4'd0) seen = 1'b1;
         m[i] = seen;
      end
      m[0] = 1'b1;
      return m;
   endfunction

   task automatic run_conv(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic [D-1:0] en);
      int n;
      bin   = v;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency", n, 17);
      chk("bcd", 32'(bcd), 32'(eb));
      chk("nz", 32'(nz), 32'(en));
      chk("busy_in_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done), 32'd0);
      chk("bcd_held", 32'(bcd), 32'(eb));
   endtask

   vec_t vecs[10];

   initial begin
      int n, dcnt, first, nd;
      int t[2];
      logic [W-1:0] rv;

      vecs[0] = '{17'd0,      24'h000000, 6'b000001};
      vecs[1] = '{17'd131071, 24'h131071, 6'b111111};
      vecs[2] = '{17'd1070,   24'h001070, 6'b001111};
      vecs[3] = '{17'd9,      24'h000009, 6'b000001};
      vecs[4] = '{17'd10,     24'h000010, 6'b000011};
      vecs[5] = '{17'd99999,  24'h099999, 6'b011111};
      vecs[6] = '{17'd100000, 24'h100000, 6'b111111};
      vecs[7] = '{17'd65536,  24'h065536, 6'b011111};
      vecs[8] = '{17'd1,      24'h000001, 6'b000001};
      vecs[9] = '{17'd500,    24'h000500, 6'b000111};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_nz", 32'(nz), 32'd0);
      rst_a_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].nz);

      // start while busy is ignored
      bin   = 17'd500;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bin   = 17'd9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 5;
      dcnt = 0;
      first = 0;
      while (n < 40) begin
         @(posedge clk);
         #1 n++;
         if (done) begin
            dcnt++;
            first = n;
            chk("ign_bcd", 32'(bcd), 32'h000500);
         end
      end
      chk("ign_done_count", dcnt, 1);
      chk("ign_latency", first, 17);

      // start held through the done cycle gives back-to-back conversions
      bin   = 17'd42;
      start = 1'b1;
      @(posedge clk);
      #1;
      n  = 0;
      nd = 0;
      t  = '{0, 0};
      while (nd < 2 && n < 60) begin
         @(posedge clk);
         #1 n++;
         if (done) begin
            t[nd] = n;
            chk("b2b_bcd", 32'(bcd), 32'h000042);
            chk("b2b_nz", 32'(nz), 32'b000011);
            chk("b2b_busy_in_done", 32'(busy), 32'd0);
            nd++;
            if (nd == 2) start = 1'b0;
         end else if (nd == 1 && n == t[0] + 1) begin
            chk("b2b_busy_restart", 32'(busy), 32'd1);
         end
      end
      chk("b2b_count", nd, 2);
      chk("b2b_first", t[0], 17);
      chk("b2b_gap", t[1] - t[0], 18);
      @(posedge clk);
      #1;
      chk("b2b_idle", 32'(busy), 32'd0);

      // asynchronous reset mid-conversion aborts with no done
      bin   = 17'd99999;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_a_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_bcd", 32'(bcd), 32'd0);
      chk("abort_nz", 32'(nz), 32'd0);
      #2 rst_a_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1;
         if (done) dcnt++;
      end
      chk("abort_no_done", dcnt, 0);
      run_conv(17'd99999, 24'h099999, 6'b011111);

      // bin changing during conversion does not disturb the captured value
      bin   = 17'd12345;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         bin = W'($urandom);
         @(posedge clk);
         #1 n++;
      end
      chk("stab_latency", n, 17);
      chk("stab_bcd", 32'(bcd), 32'h012345);
      chk("stab_nz", 32'(nz), 32'b011111);

      for (int i = 0; i < 30; i++) begin
         rv = W'($urandom_range(0, 131071));
         run_conv(rv, ref_bcd(int'(rv)), ref_nz(ref_bcd(int'(rv))));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
